// File: rtl/cache_repl_policy.sv
// Victim-way selector with run-time policy: LFSR random, per-set round-robin, or tree pseudo-LRU.
// Optional feature macro: CACHE_REPL_LOCK_EN (LockWay excludes ways from eviction, NoVictim live).
module cache_repl_policy #(
  parameter int NUMWAYS  = 4,
  parameter int SETLEN   = 9,
  parameter int NUMLINES = 128,
  parameter int LFSRLEN  = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               FlushStage,
  input  logic               CacheEn,
  input  logic [1:0]         Mode,
  input  logic [NUMWAYS-1:0] HitWay,
  input  logic [NUMWAYS-1:0] ValidWay,
  input  logic [SETLEN-1:0]  CacheSetData,
  input  logic [SETLEN-1:0]  CacheSetTag,
  input  logic               LRUWriteEn,
  input  logic               SetValid,
  input  logic               InvalidateCache,
  input  logic [NUMWAYS-1:0] LockWay,
  output logic [NUMWAYS-1:0] VictimWay,
  output logic               NoVictim
);
  localparam int WAYW = (NUMWAYS > 1) ? $clog2(NUMWAYS) : 1;
  localparam int IDXW = $clog2(NUMLINES);

  logic [LFSRLEN-1:0] lfsr_q, lfsr_d;
  logic [WAYW-1:0]    rr_q   [NUMLINES];
  logic [NUMWAYS-1:1] plru_q [NUMLINES];
  logic [WAYW-1:0]    rr_d;
  logic [NUMWAYS-1:1] plru_d;

  logic [IDXW-1:0]    rd_idx, wr_idx;
  logic [WAYW-1:0]    cand, victim, acc_way;
  logic [NUMWAYS-1:0] free;
  logic               upd, clr;
  logic               unused_set_hi;

  assign rd_idx        = CacheSetData[IDXW-1:0];
  assign wr_idx        = CacheSetTag[IDXW-1:0];
  assign unused_set_hi = ^{CacheSetData[SETLEN-1:IDXW], CacheSetTag[SETLEN-1:IDXW]};

  function automatic logic [WAYW-1:0] first_set(input logic [NUMWAYS-1:0] v);
    logic [WAYW-1:0] r;
    r = '0;
    for (int i = NUMWAYS-1; i >= 0; i--) if (v[i]) r = WAYW'(i);
    return r;
  endfunction

  // Tree nodes use heap numbering (root = 1); a node bit of 1 points to the upper half.
  function automatic logic [WAYW-1:0] plru_walk(input logic [NUMWAYS-1:1] tr);
    logic [NUMWAYS-1:0] t;
    logic [WAYW:0]      n;
    t = {tr, 1'b0};
    n = (WAYW+1)'(1);
    for (int l = 0; l < WAYW; l++) n = {n[WAYW-1:0], t[n[WAYW-1:0]]};
    return n[WAYW-1:0];
  endfunction

  function automatic logic [NUMWAYS-1:1] plru_touch(input logic [NUMWAYS-1:1] tr,
                                                    input logic [WAYW-1:0]    a);
    logic [NUMWAYS-1:0] t;
    logic [WAYW:0]      n;
    logic [WAYW-1:0]    s;
    logic               b;
    t = {tr, 1'b0};
    n = (WAYW+1)'(1);
    s = a;
    for (int l = 0; l < WAYW; l++) begin
      b = s[WAYW-1];
      t[n[WAYW-1:0]] = ~b;
      n = {n[WAYW-1:0], b};
      s = s << 1;
    end
    return t[NUMWAYS-1:1];
  endfunction

`ifdef CACHE_REPL_LOCK_EN
  function automatic logic [WAYW-1:0] skip_locked(input logic [WAYW-1:0]    c,
                                                   input logic [NUMWAYS-1:0] lk);
    logic [WAYW-1:0] r, k;
    logic            found;
    r = c;
    found = 1'b0;
    for (int i = 0; i < NUMWAYS; i++) begin
      k = c + WAYW'(i);
      if (!found && !lk[k]) begin
        r = k;
        found = 1'b1;
      end
    end
    return r;
  endfunction
`endif

  always_comb begin
    case (Mode)
      2'b01:   cand = rr_q[rd_idx];
      2'b10:   cand = plru_walk(plru_q[rd_idx]);
      default: cand = lfsr_q[WAYW-1:0];
    endcase
`ifdef CACHE_REPL_LOCK_EN
    free = ~ValidWay & ~LockWay;
    if (&LockWay)   victim = '0;
    else if (|free) victim = first_set(free);
    else            victim = skip_locked(cand, LockWay);
    NoVictim = &LockWay;
`else
    free = ~ValidWay;
    if (|free) victim = first_set(free);
    else       victim = cand;
    NoVictim = 1'b0;
`endif
  end

`ifndef CACHE_REPL_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^LockWay;
`endif

  assign VictimWay = NUMWAYS'(1) << victim;

  always_comb begin
    upd     = reset_n & CacheEn & ~FlushStage & LRUWriteEn & ~InvalidateCache;
    clr     = CacheEn & ~FlushStage & InvalidateCache;
    lfsr_d  = lfsr_q;
    if (upd) lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[4], lfsr_q[LFSRLEN-1:1]};
    acc_way = (|HitWay) ? first_set(HitWay) : victim;
    rr_d    = rr_q[wr_idx] + WAYW'(SetValid);
    plru_d  = plru_touch(plru_q[wr_idx], acc_way);
  end

  // Writes land at the edge, so a same-cycle read of the written set still sees the old entry.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lfsr_q <= LFSRLEN'(1);
      for (int i = 0; i < NUMLINES; i++) begin
        rr_q[i]   <= '0;
        plru_q[i] <= '0;
      end
    end else begin
      lfsr_q <= lfsr_d;
      if (clr) begin
        for (int i = 0; i < NUMLINES; i++) begin
          rr_q[i]   <= '0;
          plru_q[i] <= '0;
        end
      end else if (upd) begin
        rr_q[wr_idx]   <= rr_d;
        plru_q[wr_idx] <= plru_d;
      end
    end
  end

  hitway_onehot_a: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(HitWay));

endmodule

// File: tb/tb_cache_repl_policy.sv
// Randomized bench for cache_repl_policy against a behavioural replacement model.
module tb_cache_repl_policy;
  localparam int NW = 4;
  localparam int L  = 2;
  localparam int NS = 128;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          FlushStage, CacheEn, LRUWriteEn, SetValid, InvalidateCache;
  logic [1:0]    Mode;
  logic [NW-1:0] HitWay, ValidWay, LockWay, VictimWay;
  logic [8:0]    CacheSetData, CacheSetTag;
  logic          NoVictim;

  cache_repl_policy #(.NUMWAYS(NW), .SETLEN(9), .NUMLINES(NS), .LFSRLEN(8)) dut (
    .clk(clk), .reset_n(reset_n), .FlushStage(FlushStage), .CacheEn(CacheEn), .Mode(Mode),
    .HitWay(HitWay), .ValidWay(ValidWay), .CacheSetData(CacheSetData), .CacheSetTag(CacheSetTag),
    .LRUWriteEn(LRUWriteEn), .SetValid(SetValid), .InvalidateCache(InvalidateCache),
    .LockWay(LockWay), .VictimWay(VictimWay), .NoVictim(NoVictim)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference state: LFSR as an integer, a round-robin count and a node-indexed tree per set.
  int m_lfsr;
  int m_rr [NS];
  bit m_tree [NS][NW];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [NW-1:0] eff_lock();
`ifdef CACHE_REPL_LOCK_EN
    return LockWay;
`else
    return '0;
`endif
  endfunction

  function automatic void m_clear();
    for (int s = 0; s < NS; s++) begin
      m_rr[s] = 0;
      for (int n = 0; n < NW; n++) m_tree[s][n] = 1'b0;
    end
  endfunction

  function automatic void m_reset();
    m_lfsr = 1;
    m_clear();
  endfunction

  function automatic int m_walk(input int s);
    int node;
    node = 1;
    for (int l = 0; l < L; l++) node = 2 * node + (m_tree[s][node] ? 1 : 0);
    return node - NW;
  endfunction

  function automatic void m_touch(input int s, input int a);
    int node, dir;
    node = 1;
    for (int l = 0; l < L; l++) begin
      dir = (a >> (L - 1 - l)) & 1;
      m_tree[s][node] = (dir == 0);
      node = 2 * node + dir;
    end
  endfunction

  function automatic void m_victim(output int way, output bit nov);
    logic [NW-1:0] lk;
    int s, c, w;
    lk = eff_lock();
    s = int'(CacheSetData) % NS;
    way = 0;
    nov = 1'b0;
    for (int i = 0; i < NW; i++)
      if (!ValidWay[i] && !lk[i]) begin way = i; return; end
    if (lk == '1) begin nov = 1'b1; return; end
    case (Mode)
      2'b01:   c = m_rr[s];
      2'b10:   c = m_walk(s);
      default: c = m_lfsr % NW;
    endcase
    for (int k = 0; k < NW; k++) begin
      w = (c + k) % NW;
      if (!lk[w]) begin way = w; return; end
    end
  endfunction

  function automatic void m_step(input int v);
    int st, a, fb;
    st = int'(CacheSetTag) % NS;
    if (!reset_n) m_reset();
    else if (CacheEn && !FlushStage && InvalidateCache) m_clear();
    else if (CacheEn && !FlushStage && LRUWriteEn) begin
      a = v;
      for (int i = 0; i < NW; i++) if (HitWay[i]) a = i;
      fb = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 4)) & 1;
      m_lfsr = (m_lfsr >> 1) | (fb << 7);
      if (SetValid) m_rr[st] = (m_rr[st] + 1) % NW;
      m_touch(st, a);
    end
  endfunction

  // Inputs are stable from just after the rising edge, so the falling edge sees what the DUT will sample.
  always @(negedge clk) begin : cmp_proc
    int v;
    bit nv;
    if (chk_en) begin
      m_victim(v, nv);
      check("cyc_victim", 32'(VictimWay), 32'(1) << v);
      check("cyc_novictim", 32'(NoVictim), 32'(nv));
      m_step(v);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    FlushStage = 1'b0; CacheEn = 1'b1; Mode = 2'b00; HitWay = '0; ValidWay = '1;
    CacheSetData = '0; CacheSetTag = '0; LRUWriteEn = 1'b0; SetValid = 1'b0;
    InvalidateCache = 1'b0; LockWay = '0;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic set_sel(input logic [8:0] s);
    CacheSetData = s;
    CacheSetTag  = s;
  endtask

  logic [NW-1:0] exp_v [5];
  int            exp_l [3];
  int            cnt, k, r;
  bit            zero_seen, early;

  initial begin
    reset_n = 1'b0;
    set_idle();
    ValidWay = '0;
    m_reset();
    tick();
    chk_en = 1'b1;

    // Reset state
    #2 check("rst_victim", 32'(VictimWay), 32'b0001);
    check("rst_novictim", 32'(NoVictim), 32'd0);
    tick();
    ValidWay = '1;
    #2 check("rst_lfsr_victim", 32'(VictimWay), 32'b0010);
    tick();
    reset_n = 1'b1;

    // LFSR sequence 01 -> 80 -> 40 -> 20
    exp_v[0] = 4'b0010; exp_v[1] = 4'b0001; exp_v[2] = 4'b0001;
    exp_l[0] = 'h01;    exp_l[1] = 'h80;    exp_l[2] = 'h40;
    LRUWriteEn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2 check("lfsr_seq_victim", 32'(VictimWay), 32'(exp_v[i]));
      check("lfsr_seq_model", 32'(m_lfsr), 32'(exp_l[i]));
      tick();
    end
    LRUWriteEn = 1'b0;
    #2 check("lfsr_seq_model_end", 32'(m_lfsr), 32'h20);
    tick();

    // Full period with interleaved flush cycles that must not advance it
    pulse_reset();
    LRUWriteEn = 1'b1;
    cnt = 0; k = 0; zero_seen = 1'b0; early = 1'b0;
    while (cnt < 255) begin
      FlushStage = (k % 7 == 3);
      if (!FlushStage) cnt++;
      k++;
      tick();
      if (m_lfsr == 0) zero_seen = 1'b1;
      if (cnt < 255 && m_lfsr == 1) early = 1'b1;
    end
    FlushStage = 1'b0; LRUWriteEn = 1'b0;
    #2 check("lfsr_period_model", 32'(m_lfsr), 32'h01);
    check("lfsr_period_victim", 32'(VictimWay), 32'b0010);
    check("lfsr_never_zero", 32'(zero_seen), 32'd0);
    check("lfsr_no_early_wrap", 32'(early), 32'd0);
    tick();

    // PLRU: hits on 0,1,2,3 then victim 0; another hit on 0 then victim 2
    pulse_reset();
    Mode = 2'b10; set_sel(9'd3); LRUWriteEn = 1'b1;
    for (int w = 0; w < NW; w++) begin
      HitWay = NW'(1) << w;
      tick();
    end
    HitWay = '0; LRUWriteEn = 1'b0;
    #2 check("plru_after_4hits", 32'(VictimWay), 32'b0001);
    check("plru_model_walk", 32'(m_walk(3)), 32'd0);
    HitWay = 4'b0001; LRUWriteEn = 1'b1;
    tick();
    HitWay = '0; LRUWriteEn = 1'b0;
    #2 check("plru_after_hit0", 32'(VictimWay), 32'b0100);
    tick();

    // FIFO: five fills to set 7, set 8 untouched, invalidate clears
    pulse_reset();
    Mode = 2'b01; set_sel(9'd7); SetValid = 1'b1; LRUWriteEn = 1'b1;
    exp_v[0] = 4'b0001; exp_v[1] = 4'b0010; exp_v[2] = 4'b0100; exp_v[3] = 4'b1000; exp_v[4] = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      #2 check("fifo_fill_victim", 32'(VictimWay), 32'(exp_v[i]));
      tick();
    end
    SetValid = 1'b0; LRUWriteEn = 1'b0; CacheSetData = 9'd8;
    #2 check("fifo_other_set", 32'(VictimWay), 32'b0001);
    check("fifo_model_rr", 32'(m_rr[7]), 32'd1);
    tick();
    CacheSetData = 9'd7;
    #2 check("fifo_set7_before_inv", 32'(VictimWay), 32'b0010);
    tick();
    InvalidateCache = 1'b1;
    tick();
    InvalidateCache = 1'b0;
    #2 check("fifo_after_inv", 32'(VictimWay), 32'b0001);
    tick();

    // Invalid way wins in every mode
    ValidWay = 4'b1011;
    for (int m = 0; m < 4; m++) begin
      Mode = 2'(m);
      #2 check("invalid_way_first", 32'(VictimWay), 32'b0100);
      tick();
    end
    ValidWay = '1;

    // Same-cycle read/write to one set sees old state; CacheEn=0 freezes it
    Mode = 2'b01; set_sel(9'd9); SetValid = 1'b1; LRUWriteEn = 1'b1;
    #2 check("same_cycle_old", 32'(VictimWay), 32'b0001);
    tick();
    SetValid = 1'b0; LRUWriteEn = 1'b0;
    #2 check("same_cycle_new", 32'(VictimWay), 32'b0010);
    tick();
    CacheEn = 1'b0; SetValid = 1'b1; LRUWriteEn = 1'b1;
    tick();
    CacheEn = 1'b1; SetValid = 1'b0; LRUWriteEn = 1'b0;
    #2 check("cacheen_freeze", 32'(VictimWay), 32'b0010);
    tick();

    // Locking
    pulse_reset();
    Mode = 2'b01; set_sel(9'd2); SetValid = 1'b1; LRUWriteEn = 1'b1;
    tick();
    SetValid = 1'b0; LRUWriteEn = 1'b0;
`ifdef CACHE_REPL_LOCK_EN
    LockWay = 4'b0110;
    #2 check("lock_skip_victim", 32'(VictimWay), 32'b1000);
    check("lock_skip_novictim", 32'(NoVictim), 32'd0);
    tick();
    LockWay = 4'hF;
    #2 check("lock_all_victim", 32'(VictimWay), 32'b0001);
    check("lock_all_novictim", 32'(NoVictim), 32'd1);
    tick();
`else
    LockWay = 4'hF;
    #2 check("lock_ignored_victim", 32'(VictimWay), 32'b0010);
    check("lock_ignored_novictim", 32'(NoVictim), 32'd0);
    tick();
`endif
    LockWay = '0;

    // Randomized traffic, checked every cycle by cmp_proc
    for (int i = 0; i < 3000; i++) begin
      reset_n    = ($urandom_range(0, 199) != 0);
      CacheEn    = ($urandom_range(0, 15) != 0);
      FlushStage = ($urandom_range(0, 7) == 0);
      Mode       = 2'($urandom_range(0, 3));
      r          = $urandom_range(0, 2 * NW - 1);
      HitWay     = (r < NW) ? (NW'(1) << r) : '0;
      ValidWay   = ($urandom_range(0, 3) == 0) ? NW'($urandom) : '1;
      CacheSetData = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, NS - 1)) : 9'($urandom_range(0, 7));
      CacheSetTag  = ($urandom_range(0, 1) == 1) ? CacheSetData : 9'($urandom_range(0, 7));
      LRUWriteEn = 1'($urandom_range(0, 1));
      SetValid   = (HitWay == '0) && ($urandom_range(0, 1) == 1);
      InvalidateCache = CacheEn && !FlushStage && ($urandom_range(0, 63) == 0);
      LockWay    = ($urandom_range(0, 3) == 0) ? NW'($urandom) : '0;
      tick();
    end

    reset_n = 1'b1;
    set_idle();
    tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
